// File: rtl/ctrl_pipe_unit.sv
// ============================================================================
// Module   : ctrl_pipe_unit
// Brief    : Main decoder plus ID/EX, EX/MEM, MEM/WB control pipeline with
//            load-use bubble insertion, hold, flush and a bubble counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ctrl_pipe_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 3,
    parameter int CNT_W      = 16,
    parameter int HAZARD_EN  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  hold,
    input  logic                  flush,
    output logic                  load_use_stall,
    output logic                  ex_alusrc,
    output logic [ALUOP_W-1:0]    ex_aluop,
    output logic                  ex_regdst,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_branch,
    output logic                  mem_branch_ne,
    output logic                  mem_jump,
    output logic [REG_ADDR_W-1:0] mem_dest,
    output logic                  wb_regwrite,
    output logic                  wb_memtoreg,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic [CNT_W-1:0]      bubble_count
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    typedef struct packed {
        logic                  regdst;
        logic                  alusrc;
        logic                  memtoreg;
        logic                  regwrite;
        logic                  memread;
        logic                  memwrite;
        logic                  branch;
        logic                  branch_ne;
        logic                  jump;
        logic [ALUOP_W-1:0]    aluop;
        logic [REG_ADDR_W-1:0] dest;
    } idex_t;

    typedef struct packed {
        logic                  memread;
        logic                  memwrite;
        logic                  branch;
        logic                  branch_ne;
        logic                  jump;
        logic                  regwrite;
        logic                  memtoreg;
        logic [REG_ADDR_W-1:0] dest;
    } exmem_t;

    typedef struct packed {
        logic                  regwrite;
        logic                  memtoreg;
        logic [REG_ADDR_W-1:0] dest;
    } memwb_t;

    idex_t           w_dec;
    logic            w_uses_rt;
    logic            w_hazard;
    logic            w_bubble;
    idex_t           idex_q,  idex_d;
    exmem_t          exmem_q, exmem_d;
    memwb_t          memwb_q, memwb_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    always_comb begin
        w_dec     = '0;
        w_uses_rt = 1'b0;
        case (id_opcode)
            c_OP_RTYPE: begin
                w_dec.regdst     = 1'b1;
                w_dec.regwrite   = 1'b1;
                w_dec.aluop[2:0] = 3'b010;
                w_uses_rt        = 1'b1;
            end
            c_OP_LW: begin
                w_dec.alusrc   = 1'b1;
                w_dec.memtoreg = 1'b1;
                w_dec.regwrite = 1'b1;
                w_dec.memread  = 1'b1;
            end
            c_OP_SW: begin
                w_dec.alusrc   = 1'b1;
                w_dec.memwrite = 1'b1;
                w_uses_rt      = 1'b1;
            end
            c_OP_BEQ: begin
                w_dec.branch     = 1'b1;
                w_dec.aluop[2:0] = 3'b001;
                w_uses_rt        = 1'b1;
            end
            c_OP_BNE: begin
                w_dec.branch     = 1'b1;
                w_dec.branch_ne  = 1'b1;
                w_dec.aluop[2:0] = 3'b001;
                w_uses_rt        = 1'b1;
            end
            c_OP_ADDI: begin
                w_dec.alusrc   = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            c_OP_ANDI: begin
                w_dec.alusrc     = 1'b1;
                w_dec.regwrite   = 1'b1;
                w_dec.aluop[2:0] = 3'b011;
            end
            c_OP_ORI: begin
                w_dec.alusrc     = 1'b1;
                w_dec.regwrite   = 1'b1;
                w_dec.aluop[2:0] = 3'b100;
            end
            c_OP_J: begin
                w_dec.jump = 1'b1;
            end
            default: ;
        endcase
        // Non-writing instructions carry dest 0 so they can never match a hazard.
        if (w_dec.regwrite) begin
            w_dec.dest = w_dec.regdst ? id_rd : id_rt;
        end
    end

    generate
        if (HAZARD_EN != 0) begin : g_hazard
            assign w_hazard = idex_q.memread && (idex_q.dest != '0) &&
                              ((idex_q.dest == id_rs) ||
                               (w_uses_rt && (idex_q.dest == id_rt)));
        end else begin : g_no_hazard
            assign w_hazard = 1'b0;
        end
    endgenerate

    assign load_use_stall = w_hazard & ~flush & ~reset;

    always_comb begin
        idex_d   = idex_q;
        exmem_d  = exmem_q;
        memwb_d  = memwb_q;
        cnt_d    = cnt_q;
        w_bubble = 1'b0;
        if (!hold) begin
            memwb_d.regwrite = exmem_q.regwrite;
            memwb_d.memtoreg = exmem_q.memtoreg;
            memwb_d.dest     = exmem_q.dest;
            if (flush) begin
                idex_d   = '0;
                exmem_d  = '0;
                w_bubble = 1'b1;
            end else begin
                exmem_d.memread   = idex_q.memread;
                exmem_d.memwrite  = idex_q.memwrite;
                exmem_d.branch    = idex_q.branch;
                exmem_d.branch_ne = idex_q.branch_ne;
                exmem_d.jump      = idex_q.jump;
                exmem_d.regwrite  = idex_q.regwrite;
                exmem_d.memtoreg  = idex_q.memtoreg;
                exmem_d.dest      = idex_q.dest;
                if (w_hazard) begin
                    idex_d   = '0;
                    w_bubble = 1'b1;
                end else begin
                    idex_d = w_dec;
                end
            end
            if (w_bubble && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            cnt_q   <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_alusrc     = idex_q.alusrc;
    assign ex_aluop      = idex_q.aluop;
    assign ex_regdst     = idex_q.regdst;
    assign ex_dest       = idex_q.dest;
    assign mem_read      = exmem_q.memread;
    assign mem_write     = exmem_q.memwrite;
    assign mem_branch    = exmem_q.branch;
    assign mem_branch_ne = exmem_q.branch_ne;
    assign mem_jump      = exmem_q.jump;
    assign mem_dest      = exmem_q.dest;
    assign wb_regwrite   = memwb_q.regwrite;
    assign wb_memtoreg   = memwb_q.memtoreg;
    assign wb_dest       = memwb_q.dest;
    assign bubble_count  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe_unit.sv
// ============================================================================
// Module   : tb_ctrl_pipe_unit
// Brief    : Self-checking bench for ctrl_pipe_unit against an instruction-level
//            pipeline model; a CNT_W=2 copy and a HAZARD_EN=0 copy share stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ctrl_pipe_unit;

    localparam logic [5:0] c_R    = 6'b000000;
    localparam logic [5:0] c_LW   = 6'b100011;
    localparam logic [5:0] c_SW   = 6'b101011;
    localparam logic [5:0] c_BEQ  = 6'b000100;
    localparam logic [5:0] c_BNE  = 6'b000101;
    localparam logic [5:0] c_ADDI = 6'b001000;
    localparam logic [5:0] c_ANDI = 6'b001100;
    localparam logic [5:0] c_ORI  = 6'b001101;
    localparam logic [5:0] c_J    = 6'b000010;
    localparam logic [5:0] c_BAD  = 6'b111111;

    logic       clk, reset, hold, flush;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, id_rd;

    logic       load_use_stall, ex_alusrc, ex_regdst, mem_read, mem_write;
    logic       mem_branch, mem_branch_ne, mem_jump, wb_regwrite, wb_memtoreg;
    logic [2:0] ex_aluop;
    logic [4:0] ex_dest, mem_dest, wb_dest;
    logic [15:0] bubble_count;

    logic       stall_s, alusrc_s, regdst_s, mrd_s, mwr_s, mbr_s, mbne_s, mj_s, rw_s, m2r_s;
    logic [2:0] aluop_s;
    logic [4:0] exd_s, memd_s, wbd_s;
    logic [1:0] bubble_count_s;

    logic       stall_n, alusrc_n, regdst_n, mrd_n, mwr_n, mbr_n, mbne_n, mj_n, rw_n, m2r_n;
    logic [2:0] aluop_n;
    logic [4:0] exd_n, memd_n, wbd_n;
    logic [15:0] bubble_count_n;

    ctrl_pipe_unit u_dut (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .hold(hold), .flush(flush), .load_use_stall(load_use_stall),
        .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .ex_regdst(ex_regdst), .ex_dest(ex_dest),
        .mem_read(mem_read), .mem_write(mem_write), .mem_branch(mem_branch),
        .mem_branch_ne(mem_branch_ne), .mem_jump(mem_jump), .mem_dest(mem_dest),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_dest(wb_dest),
        .bubble_count(bubble_count)
    );

    ctrl_pipe_unit #(.CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .hold(hold), .flush(flush), .load_use_stall(stall_s),
        .ex_alusrc(alusrc_s), .ex_aluop(aluop_s), .ex_regdst(regdst_s), .ex_dest(exd_s),
        .mem_read(mrd_s), .mem_write(mwr_s), .mem_branch(mbr_s),
        .mem_branch_ne(mbne_s), .mem_jump(mj_s), .mem_dest(memd_s),
        .wb_regwrite(rw_s), .wb_memtoreg(m2r_s), .wb_dest(wbd_s),
        .bubble_count(bubble_count_s)
    );

    ctrl_pipe_unit #(.HAZARD_EN(0)) u_dut_nohaz (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .hold(hold), .flush(flush), .load_use_stall(stall_n),
        .ex_alusrc(alusrc_n), .ex_aluop(aluop_n), .ex_regdst(regdst_n), .ex_dest(exd_n),
        .mem_read(mrd_n), .mem_write(mwr_n), .mem_branch(mbr_n),
        .mem_branch_ne(mbne_n), .mem_jump(mj_n), .mem_dest(memd_n),
        .wb_regwrite(rw_n), .wb_memtoreg(m2r_n), .wb_dest(wbd_n),
        .bubble_count(bubble_count_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    wire [26:0] dut_vec = {ex_alusrc, ex_aluop, ex_regdst, ex_dest,
                           mem_read, mem_write, mem_branch, mem_branch_ne, mem_jump, mem_dest,
                           wb_regwrite, wb_memtoreg, wb_dest};

    // Instruction-level model: each stage holds the whole decoded instruction.
    typedef struct packed {
        logic       regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, bne, jump;
        logic [2:0] aluop;
        logic [4:0] dest;
    } ins_t;

    ins_t m_ex, m_mem, m_wb;
    int   m_cnt, m_cnt2;
    int   n_tests, n_fail;

    function automatic ins_t decode(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
        ins_t b;
        b = '0;
        if (op == c_R)         {b.regdst, b.regwrite, b.aluop} = {2'b11, 3'b010};
        else if (op == c_LW)   {b.alusrc, b.memtoreg, b.regwrite, b.memread} = 4'b1111;
        else if (op == c_SW)   {b.alusrc, b.memwrite} = 2'b11;
        else if (op == c_BEQ)  {b.branch, b.aluop} = {1'b1, 3'b001};
        else if (op == c_BNE)  {b.branch, b.bne, b.aluop} = {2'b11, 3'b001};
        else if (op == c_ADDI) {b.alusrc, b.regwrite} = 2'b11;
        else if (op == c_ANDI) {b.alusrc, b.regwrite, b.aluop} = {2'b11, 3'b011};
        else if (op == c_ORI)  {b.alusrc, b.regwrite, b.aluop} = {2'b11, 3'b100};
        else if (op == c_J)    b.jump = 1'b1;
        b.dest = !b.regwrite ? 5'd0 : (b.regdst ? rd : rt);
        return b;
    endfunction

    function automatic logic model_hazard(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        logic reads_rt;
        reads_rt = (op == c_R) || (op == c_SW) || (op == c_BEQ) || (op == c_BNE);
        return m_ex.memread && (m_ex.dest != 0) &&
               ((m_ex.dest == rs) || (reads_rt && (m_ex.dest == rt)));
    endfunction

    function automatic logic [26:0] exp_vec();
        return {m_ex.alusrc, m_ex.aluop, m_ex.regdst, m_ex.dest,
                m_mem.memread, m_mem.memwrite, m_mem.branch, m_mem.bne, m_mem.jump, m_mem.dest,
                m_wb.regwrite, m_wb.memtoreg, m_wb.dest};
    endfunction

    task automatic model_step(input logic [5:0] op, input logic [4:0] rs, rt, rd,
                              input logic hld, fl, rst);
        logic hz;
        hz = model_hazard(op, rs, rt);
        if (rst) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0; m_cnt2 = 0;
        end else if (!hld) begin
            m_wb = m_mem;
            if (fl) begin
                m_mem = '0; m_ex = '0;
            end else begin
                m_mem = m_ex;
                m_ex  = hz ? '0 : decode(op, rt, rd);
            end
            if (fl || hz) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    endtask

    // Drive one cycle: sample the combinational stall mid-cycle, then step the model.
    task automatic tick(input logic [5:0] op, input logic [4:0] rs, rt, rd,
                        input logic hld, fl, rst,
                        output logic st_d, output logic st_e, output logic st_n);
        id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
        hold = hld; flush = fl; reset = rst;
        #1;
        st_d = load_use_stall;
        st_n = stall_n;
        st_e = model_hazard(op, rs, rt) & ~fl & ~rst;
        @(posedge clk);
        model_step(op, rs, rt, rd, hld, fl, rst);
        #1;
    endtask

    task automatic test_reset();
        logic sd, se, sn;
        for (int i = 0; i < 2; i++) begin
            tick(c_LW, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, sd, se, sn);
            n_tests++;
            if ({dut_vec, bubble_count, sd} !== 44'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc%0d: got %h/%0d/%b want all zero", i, dut_vec, bubble_count, sd);
            end
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (dut_vec !== 27'd0) begin
            n_fail++;
            $display("FAIL after_release: got %h want 0", dut_vec);
        end
        for (int i = 0; i < 3; i++) begin
            tick(c_LW, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, sd, se, sn);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        n_tests++;
        if ({ex_aluop, mem_read, wb_memtoreg} !== 5'b00011) begin
            n_fail++;
            $display("FAIL reset_idle_lw: got aluop=%b mr=%b m2r=%b want 000/1/1", ex_aluop, mem_read, wb_memtoreg);
        end
    endtask

    task automatic test_decode_sweep();
        logic [5:0] ops [10];
        logic sd, se, sn;
        ops = '{c_R, c_LW, c_SW, c_BEQ, c_BNE, c_ADDI, c_ANDI, c_ORI, c_J, c_BAD};
        for (int i = 0; i < 12; i++) begin
            tick((i < 10) ? ops[i] : c_BAD, 5'd0, 5'(i + 10), 5'(i + 20),
                 1'b0, 1'b0, 1'b0, sd, se, sn);
            n_tests++;
            if ((dut_vec !== exp_vec()) || (sd !== se)) begin
                n_fail++;
                $display("FAIL decode_sweep %0d: got %h st=%b want %h st=%b", i, dut_vec, sd, exp_vec(), se);
            end
            if (i == 5) begin
                n_tests++;
                if ({mem_branch, mem_branch_ne} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL bne_mem: got %b%b want 11", mem_branch, mem_branch_ne);
                end
            end
        end
    endtask

    task automatic test_load_use();
        logic sd, se, sn;
        int c0;
        tick(c_LW, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, sd, se, sn);
        c0 = int'(bubble_count);
        tick(c_R, 5'd5, 5'd1, 5'd3, 1'b0, 1'b0, 1'b0, sd, se, sn);
        n_tests++;
        if ((sd !== 1'b1) || (sd !== se)) begin
            n_fail++;
            $display("FAIL load_use_stall: got %b want 1", sd);
        end
        n_tests++;
        if ((dut_vec !== exp_vec()) || ({ex_alusrc, ex_aluop, ex_regdst, ex_dest} !== 10'd0) ||
            (int'(bubble_count) != c0 + 1) || (bubble_count !== 16'(m_cnt))) begin
            n_fail++;
            $display("FAIL load_use_bubble: got %h cnt=%0d want %h cnt=%0d", dut_vec, bubble_count, exp_vec(), c0 + 1);
        end
        tick(c_R, 5'd5, 5'd1, 5'd3, 1'b0, 1'b0, 1'b0, sd, se, sn);
        n_tests++;
        if ((sd !== 1'b0) || (dut_vec !== exp_vec()) || (ex_dest !== 5'd3)) begin
            n_fail++;
            $display("FAIL load_use_reissue: got st=%b %h want st=0 %h", sd, dut_vec, exp_vec());
        end
        tick(c_LW, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, sd, se, sn);
        tick(c_R, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, sd, se, sn);
        n_tests++;
        if ((sd !== 1'b0) || (se !== 1'b0) || (dut_vec !== exp_vec())) begin
            n_fail++;
            $display("FAIL load_use_dest0: got st=%b %h want st=0 %h", sd, dut_vec, exp_vec());
        end
    endtask

    task automatic test_rt_only();
        logic sd, se, sn;
        tick(c_LW, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, sd, se, sn);
        tick(c_ADDI, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, sd, se, sn);
        n_tests++;
        if ((sd !== 1'b0) || (se !== 1'b0) || (dut_vec !== exp_vec())) begin
            n_fail++;
            $display("FAIL rt_addi: got st=%b %h want st=0 %h", sd, dut_vec, exp_vec());
        end
        tick(c_LW, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, sd, se, sn);
        tick(c_SW, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, sd, se, sn);
        n_tests++;
        if ((sd !== 1'b1) || (se !== 1'b1) || (dut_vec !== exp_vec())) begin
            n_fail++;
            $display("FAIL rt_sw: got st=%b %h want st=1 %h", sd, dut_vec, exp_vec());
        end
    endtask

    task automatic test_flush_vs_hazard();
        logic sd, se, sn;
        int c0;
        tick(c_R, 5'd0, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0, sd, se, sn);
        tick(c_LW, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, sd, se, sn);
        c0 = int'(bubble_count);
        tick(c_R, 5'd5, 5'd1, 5'd3, 1'b0, 1'b1, 1'b0, sd, se, sn);
        n_tests++;
        if ((sd !== 1'b0) || (dut_vec !== exp_vec()) || (dut_vec[26:7] !== 20'd0) ||
            ({wb_regwrite, wb_dest} !== {1'b1, 5'd9}) || (int'(bubble_count) != c0 + 1)) begin
            n_fail++;
            $display("FAIL flush_hazard: got st=%b %h cnt=%0d want st=0 %h cnt=%0d",
                     sd, dut_vec, bubble_count, exp_vec(), c0 + 1);
        end
    endtask

    task automatic test_hold();
        logic sd, se, sn;
        logic [26:0] snap;
        tick(c_LW, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, sd, se, sn);
        snap = exp_vec();
        for (int i = 0; i < 3; i++) begin
            tick((i == 0) ? c_R : ((i == 1) ? c_ORI : c_J), 5'd6, 5'd6, 5'd2,
                 1'b1, 1'(i == 2), 1'b0, sd, se, sn);
            n_tests++;
            if ((dut_vec !== snap) || (bubble_count !== 16'(m_cnt)) || (sd !== se)) begin
                n_fail++;
                $display("FAIL hold %0d: got %h cnt=%0d st=%b want %h cnt=%0d st=%b",
                         i, dut_vec, bubble_count, sd, snap, m_cnt, se);
            end
        end
    endtask

    task automatic test_saturation();
        logic sd, se, sn;
        tick(c_BAD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, sd, se, sn);
        for (int i = 0; i < 5; i++) begin
            tick(c_LW, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, sd, se, sn);
            tick(c_R, 5'd5, 5'd1, 5'd3, 1'b0, 1'b0, 1'b0, sd, se, sn);
        end
        n_tests++;
        if ((bubble_count_s !== 2'd3) || (bubble_count !== 16'd5)) begin
            n_fail++;
            $display("FAIL saturation: got cnt2=%0d cnt16=%0d want 3/5", bubble_count_s, bubble_count);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [10];
        logic sd, se, sn;
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        logic hld, fl, rst;
        int errs;
        ops = '{c_R, c_LW, c_SW, c_BEQ, c_BNE, c_ADDI, c_ANDI, c_ORI, c_J, c_BAD};
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            op  = (($urandom % 3) == 0) ? c_LW : ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 15) == 0) op = 6'($urandom);
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            hld = ($urandom_range(0, 9) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 49) == 0);
            tick(op, rs, rt, rd, hld, fl, rst, sd, se, sn);
            n_tests++;
            if ((sd !== se) || (sn !== 1'b0) || (dut_vec !== exp_vec()) ||
                (bubble_count !== 16'(m_cnt)) || (bubble_count_s !== 2'(m_cnt2))) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random %0d: got st=%b/%b %h cnt=%0d/%0d want st=%b/0 %h cnt=%0d/%0d",
                             i, sd, sn, dut_vec, bubble_count, bubble_count_s,
                             se, exp_vec(), m_cnt, m_cnt2);
            end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0; m_cnt2 = 0;
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        id_opcode = 6'd0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_decode_sweep();
        test_load_use();
        test_rt_only();
        test_flush_vs_hazard();
        test_hold();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Parametrised successor to the single-cycle main decoder.
- Decodes the ID-stage opcode into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB stage registers.
- Detects load-use hazards and inserts bubbles. Handles a global pipeline hold and a branch/jump flush.
- Keeps a saturating bubble counter for performance monitoring.
- Sits between the IF/ID register and the datapath stage muxes of the 5-stage core.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- ALUOP_W, 3, ALUOp width; must be >= 3.
- CNT_W, 16, bubble-counter width.
- HAZARD_EN, 1, 1 = load-use detection active; 0 = load_use_stall tied to 0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- id_opcode  in  6  opcode of the instruction in ID.
- id_rs  in  REG_ADDR_W  rs field in ID.
- id_rt  in  REG_ADDR_W  rt field in ID.
- id_rd  in  REG_ADDR_W  rd field in ID.
- hold  in  1  freeze all stage registers (memory wait).
- flush  in  1  taken branch/jump; kill the instructions in ID and EX.
- load_use_stall  out  1  combinational; the IF/ID register and PC must hold this cycle.
- ex_alusrc  out  1  EX-stage control.
- ex_aluop  out  ALUOP_W  EX-stage control.
- ex_regdst  out  1  EX-stage control.
- ex_dest  out  REG_ADDR_W  EX-stage destination register.
- mem_read  out  1  MEM-stage control.
- mem_write  out  1  MEM-stage control.
- mem_branch  out  1  MEM-stage control.
- mem_branch_ne  out  1  MEM-stage control.
- mem_jump  out  1  MEM-stage control.
- mem_dest  out  REG_ADDR_W  MEM-stage destination register.
- wb_regwrite  out  1  WB-stage control.
- wb_memtoreg  out  1  WB-stage control.
- wb_dest  out  REG_ADDR_W  WB-stage destination register.
- bubble_count  out  CNT_W  saturating count of bubbles inserted.

Behaviour:
- Decode (combinational, ID). Bundle = {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, BranchNe, Jump, ALUOp}:
  - 000000 R-type: 1,0,0,1,0,0,0,0,0, ALUOp 010.
  - 100011 lw: 0,1,1,1,1,0,0,0,0, ALUOp 000.
  - 101011 sw: 0,1,0,0,0,1,0,0,0, ALUOp 000.
  - 000100 beq: 0,0,0,0,0,0,1,0,0, ALUOp 001.
  - 000101 bne: 0,0,0,0,0,0,1,1,0, ALUOp 001.
  - 001000 addi: 0,1,0,1,0,0,0,0,0, ALUOp 000.
  - 001100 andi: 0,1,0,1,0,0,0,0,0, ALUOp 011.
  - 001101 ori: 0,1,0,1,0,0,0,0,0, ALUOp 100.
  - 000010 j: all 0 except Jump=1.
  - Any other opcode: all-zero bundle (NOP).
  - No X outputs; former don't-cares are driven 0. ALUOp upper bits above bit 2 are zero.
- Destination: id_dest = RegDst ? id_rd : id_rt. id_dest is forced to 0 when RegWrite=0.
- Uses-rt: true for R-type, sw, beq and bne.
- Load-use hazard:
  - hazard = HAZARD_EN & ex_mem_read & (ex_dest != 0) & ((ex_dest == id_rs) | (uses_rt & ex_dest == id_rt)).
  - load_use_stall = hazard & ~flush & ~reset.
- Stage update at the clock edge, highest priority first:
  1. reset: all stage registers cleared (every output 0), bubble_count = 0.
  2. hold: all stage registers and bubble_count keep their values. flush and hazard are ignored that cycle; the upstream must re-present them.
  3. flush: ID/EX and EX/MEM are loaded with a bubble (all zero). MEM/WB takes EX/MEM as normal.
  4. hazard: ID/EX is loaded with a bubble. EX/MEM and MEM/WB advance normally.
  5. Otherwise: ID/EX takes the decoded bundle, EX/MEM takes ID/EX, MEM/WB takes EX/MEM.
- Stage contents:
  - ID/EX holds the full bundle plus dest.
  - EX/MEM holds MemRead, MemWrite, Branch, BranchNe, Jump, RegWrite, MemToReg and dest.
  - MEM/WB holds RegWrite, MemToReg and dest.
  - ex_mem_read is the MemRead bit of ID/EX.
- Latency: ID decode reaches ex_* after 1 edge, mem_* after 2 edges, wb_* after 3 edges.
- bubble_count:
  - Increments by 1 on each non-hold, non-reset edge where flush or hazard inserts a bubble.
  - A flush counts as 1 per edge, not 2.
  - Saturates at 2^CNT_W-1 and never wraps.
- Reset mid-operation: all in-flight control is discarded. There are no partial writes: wb_regwrite and mem_write are 0 on the cycle after reset.

Test Plan:
- Reset then idle:
  - Assert reset 2 cycles with id_opcode=100011.
  - All outputs 0 during and 1 cycle after reset.
  - From the third edge after release: ex_aluop=000, mem_read=1 at the next stage, wb_memtoreg=1.
- Decode sweep:
  - Present each of the 9 opcodes plus 111111, one per cycle, with no hazards.
  - ex_* bundle matches the table one cycle later; 111111 gives all-zero.
  - bne yields mem_branch=1 and mem_branch_ne=1 two cycles later.
- Load-use:
  - lw with rt=5 followed by R-type with rs=5.
  - load_use_stall=1 for exactly 1 cycle; ID/EX holds a bubble; bubble_count 0 to 1.
  - Re-presented R-type issues next cycle.
  - Repeat with dest=0: no stall.
- rt-only dependency:
  - lw dest 7 then addi with rt=7: no stall.
  - lw dest 7 then sw with rt=7: stall.
- Flush vs hazard:
  - Hazard condition plus flush=1 in the same cycle.
  - load_use_stall=0; ex_* and mem_* are 0 next cycle; wb_* carries the older instruction; bubble_count increments by exactly 1.
- Hold and saturation:
  - hold=1 for 3 cycles with a changing opcode: all outputs frozen.
  - With CNT_W=2, force 5 hazards: bubble_count stops at 3.
